// File: rtl/multi_chan_pipe.sv
// multi_chan_pipe: CHANNELS independent DEPTH-stage elastic pipelines with
// bubble collapse. Each channel is a multi_chan_pipe_lane instance.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears all valid bits)
//   flush      synchronous clear of every channel
//   in_valid   [CHANNELS]        per-channel input valid
//   in_ready   [CHANNELS]        per-channel input ready
//   in_data    [CHANNELS*WIDTH]  channel c at [c*WIDTH +: WIDTH]
//   out_valid  [CHANNELS]        per-channel output valid
//   out_ready  [CHANNELS]        per-channel output ready
//   out_data   [CHANNELS*WIDTH]  same packing as in_data
//   occupancy  [CHANNELS*OW]     per-channel valid-stage count, OW=$clog2(DEPTH+1)

// One channel: a DEPTH-stage register chain.
module multi_chan_pipe_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int OW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    occupancy
);
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            en;    // stage s may load this edge
  logic [DEPTH:0]              vsrc;  // vsrc[s]: valid feeding stage s
  logic [DEPTH:0][WIDTH-1:0]   dsrc;
  logic                        acc;

  // A stage can load when it is empty or its content moves on. Because of
  // bubble collapse that is true when out_ready is high or any stage at or
  // downstream of s is empty, so a suffix OR replaces the recursive form.
  always_comb begin
    en  = '0;
    acc = out_ready;
    for (int s = DEPTH-1; s >= 0; s--) begin
      acc   = acc | !v[s];
      en[s] = acc;
    end
  end

  always_comb begin
    vsrc = {v, in_valid};
    dsrc = {d, in_data};
  end

  // en[0] already covers "stage 0 empty or advancing"; flush and reset gate it.
  assign in_ready  = rst_n & !flush & en[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++)
        if (en[s]) v[s] <= vsrc[s];
    end
  end

  // Data is not reset; it only loads when a real word enters the stage.
  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++)
      if (en[s] && vsrc[s]) d[s] <= dsrc[s];
  end

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < DEPTH; s++)
      occupancy = occupancy + OW'(v[s]);
  end
endmodule

module multi_chan_pipe #(
  parameter int CHANNELS = 1,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic [CHANNELS-1:0]                    in_valid,
  output logic [CHANNELS-1:0]                    in_ready,
  input  logic [CHANNELS*WIDTH-1:0]              in_data,
  output logic [CHANNELS-1:0]                    out_valid,
  input  logic [CHANNELS-1:0]                    out_ready,
  output logic [CHANNELS*WIDTH-1:0]              out_data,
  output logic [CHANNELS*$clog2(DEPTH+1)-1:0]    occupancy
);
  localparam int OW = $clog2(DEPTH+1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    multi_chan_pipe_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .OW    (OW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid[c]),
      .in_ready  (in_ready[c]),
      .in_data   (in_data[c*WIDTH +: WIDTH]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .out_data  (out_data[c*WIDTH +: WIDTH]),
      .occupancy (occupancy[c*OW +: OW])
    );
  end
endmodule

// File: tb/tb_multi_chan_pipe.sv
module tb_multi_chan_pipe;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int D  = 3;
  localparam int OW = $clog2(D+1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [CH-1:0]     in_valid, in_ready, out_valid, out_ready;
  logic [CH*W-1:0]   in_data, out_data;
  logic [CH*OW-1:0]  occupancy;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q [CH][$];

  multi_chan_pipe #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic v, input logic [W-1:0] dat);
    in_valid[c] = v;
    in_data[c*W +: W] = dat;
  endtask

  // Monitor / scoreboard: runs between edges, inputs are stable here.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int c = 0; c < CH; c++) begin
        logic exp_rdy;
        logic [W-1:0] w;
        chk("occupancy", c, 32'(occupancy[c*OW +: OW]), 32'(exp_q[c].size()));
        exp_rdy = !flush && (exp_q[c].size() < D || out_ready[c]);
        chk("in_ready", c, 32'(in_ready[c]), 32'(exp_rdy));
        if (out_valid[c] && out_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_out ch%0d: got %0h expected no word", c, out_data[c*W +: W]);
          end else begin
            w = exp_q[c].pop_front();
            chk("out_data", c, 32'(out_data[c*W +: W]), 32'(w));
          end
        end
        if (in_valid[c] && exp_rdy) exp_q[c].push_back(in_data[c*W +: W]);
      end
      if (flush)
        for (int c = 0; c < CH; c++) exp_q[c].delete();
    end
  end

  always @(negedge rst_n)
    for (int c = 0; c < CH; c++) exp_q[c].delete();

  initial begin
    int n [CH];
    logic [CH-1:0] acc;

    rst_n = 1'b0; flush = 1'b0; in_valid = '0; out_ready = '0; in_data = '0;
    #2;
    chk("rst_in_ready", 0, 32'(in_ready), 32'h0);
    chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_occupancy", 0, 32'(occupancy), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 0, 32'(in_ready), 32'hF);

    // Back-to-back stream with latency check.
    out_ready = '1;
    drive(0, 1'b1, 16'h0011); tick();
    drive(0, 1'b1, 16'h0022); tick();
    drive(0, 1'b1, 16'h0033); #1;
    chk("lat_early", 0, 32'(out_valid[0]), 32'h0);
    tick();
    drive(0, 1'b0, 16'h0000); #1;
    chk("lat_valid", 0, 32'(out_valid[0]), 32'h1);
    chk("lat_data", 0, 32'(out_data[15:0]), 32'h0011);
    repeat (5) tick();

    // Back-pressure on a full channel, then simultaneous in/out.
    out_ready = 4'b1110;
    drive(0, 1'b1, 16'h0101); tick();
    drive(0, 1'b1, 16'h0102); tick();
    drive(0, 1'b1, 16'h0103); tick();
    drive(0, 1'b1, 16'h0104); #1;
    chk("full_occ", 0, 32'(occupancy[OW-1:0]), 32'd3);
    chk("full_in_ready", 0, 32'(in_ready[0]), 32'h0);
    tick();
    chk("full_hold", 0, 32'(in_ready[0]), 32'h0);
    out_ready[0] = 1'b1; #1;
    chk("full_rdy_passthru", 0, 32'(in_ready[0]), 32'h1);
    tick();
    out_ready[0] = 1'b0;
    drive(0, 1'b0, 16'h0000); #1;
    chk("full_occ_kept", 0, 32'(occupancy[OW-1:0]), 32'd3);
    chk("full_in_ready2", 0, 32'(in_ready[0]), 32'h0);
    out_ready = '1;
    repeat (5) tick();

    // Channel 2 stalled while the others stream at full rate.
    out_ready = 4'b1011;
    for (int c = 0; c < CH; c++) n[c] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < CH; c++)
        drive(c, n[c] < 8, (c == 2 ? 16'hB000 : 16'hA000) + 16'(n[c]));
      #1;
      for (int c = 0; c < CH; c++)
        if (c != 2) chk("full_rate", c, 32'(in_ready[c]), 32'h1);
      acc = in_valid & in_ready;
      tick();
      for (int c = 0; c < CH; c++) n[c] += int'(acc[c]);
    end
    chk("stall_count", 2, 32'(n[2]), 32'd3);
    out_ready = '1;
    for (int k = 0; k < 10 && n[2] < 8; k++) begin
      for (int c = 0; c < CH; c++)
        drive(c, c == 2, 16'hB000 + 16'(n[2]));
      #1;
      acc = in_valid & in_ready;
      tick();
      n[2] += int'(acc[2]);
    end
    in_valid = '0;
    repeat (5) tick();

    // Flush with a word presented on the input.
    out_ready = '0;
    drive(0, 1'b1, 16'h0201); tick();
    drive(0, 1'b1, 16'h0202); tick();
    drive(0, 1'b1, 16'h0203); flush = 1'b1; #1;
    chk("flush_pre_occ", 0, 32'(occupancy[OW-1:0]), 32'd2);
    chk("flush_in_ready", 0, 32'(in_ready[0]), 32'h0);
    tick();
    flush = 1'b0; drive(0, 1'b0, 16'h0000); #1;
    chk("flush_occ", 0, 32'(occupancy[OW-1:0]), 32'd0);
    chk("flush_out_valid", 0, 32'(out_valid[0]), 32'h0);
    out_ready = '1;
    drive(0, 1'b1, 16'h0204); tick();
    drive(0, 1'b0, 16'h0000);
    repeat (5) tick();

    // Asynchronous reset pulse between edges with two words in flight.
    out_ready = '0;
    drive(0, 1'b1, 16'h0301); tick();
    drive(0, 1'b1, 16'h0302); tick();
    drive(0, 1'b0, 16'h0000); tick(); tick(); #1;
    chk("pre_rst_valid", 0, 32'(out_valid[0]), 32'h1);
    chk("pre_rst_occ", 0, 32'(occupancy[OW-1:0]), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 0, 32'(out_valid), 32'h0);
    chk("arst_occ", 0, 32'(occupancy), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_in_ready", 0, 32'(in_ready), 32'hF);
    out_ready = '1;
    drive(0, 1'b1, 16'h0303); tick();
    drive(0, 1'b0, 16'h0000); tick(); #1;
    chk("arst_lat_early", 0, 32'(out_valid[0]), 32'h0);
    tick();
    chk("arst_lat_valid", 0, 32'(out_valid[0]), 32'h1);
    chk("arst_lat_data", 0, 32'(out_data[15:0]), 32'h0303);
    repeat (4) tick();

    // Random valid/ready/flush traffic on all channels.
    for (int k = 0; k < 400; k++) begin
      in_valid  = CH'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = CH'($urandom);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0; in_valid = '0; out_ready = '1;
    repeat (D + 3) tick();
    for (int c = 0; c < CH; c++)
      chk("drain_empty", c, 32'(exp_q[c].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
